// File: rtl/pellet_tracker_pkg.sv
// Shared maze-game definitions: geometry, tracker FSM states and the
// default pellet layout used by the game top.
package pellet_tracker_pkg;

    localparam int unsigned SCREEN_W      = 640;
    localparam int unsigned SCREEN_H      = 480;
    localparam int unsigned SPRITE_EDGE   = 20;
    localparam int unsigned PELLET_EDGE   = 15;
    localparam int unsigned DEF_COORD_W   = 10;
    localparam int unsigned DEF_N_PELLETS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SCAN,
        CHECK,
        WON
    } tracker_state_t;

    // Columns 147/478, rows 50/141/304/395; pellet 0 sits in the low slice.
    localparam logic [DEF_N_PELLETS*DEF_COORD_W-1:0] DEF_PELLET_X = {
        10'd478, 10'd478, 10'd478, 10'd478,
        10'd147, 10'd147, 10'd147, 10'd147
    };
    localparam logic [DEF_N_PELLETS*DEF_COORD_W-1:0] DEF_PELLET_Y = {
        10'd395, 10'd304, 10'd141, 10'd50,
        10'd395, 10'd304, 10'd141, 10'd50
    };

endpackage

// File: rtl/pellet_tracker_rect.sv
// Box-in-box comparator, widened by one bit so edges near the top of the
// coordinate range cannot wrap. STRICT selects open bounds (render test).
module rect_contains #(
    parameter int unsigned W        = 10,
    parameter int unsigned OUTER_SZ = 20,
    parameter int unsigned INNER_SZ = 15,
    parameter bit          STRICT   = 1'b0
) (
    input  logic [W-1:0] outer_x_i,
    input  logic [W-1:0] outer_y_i,
    input  logic [W-1:0] inner_x_i,
    input  logic [W-1:0] inner_y_i,
    output logic         hit_o
);

    logic [W:0] ox_lo, oy_lo, ox_hi, oy_hi;
    logic [W:0] ix_lo, iy_lo, ix_hi, iy_hi;

    always_comb begin
        ox_lo = {1'b0, outer_x_i};
        oy_lo = {1'b0, outer_y_i};
        ix_lo = {1'b0, inner_x_i};
        iy_lo = {1'b0, inner_y_i};
        ox_hi = ox_lo + (W+1)'(OUTER_SZ);
        oy_hi = oy_lo + (W+1)'(OUTER_SZ);
        ix_hi = ix_lo + (W+1)'(INNER_SZ);
        iy_hi = iy_lo + (W+1)'(INNER_SZ);
        if (STRICT) begin
            hit_o = (ox_lo < ix_lo) && (ox_hi > ix_hi) &&
                    (oy_lo < iy_lo) && (oy_hi > iy_hi);
        end else begin
            hit_o = (ox_lo <= ix_lo) && (ox_hi >= ix_hi) &&
                    (oy_lo <= iy_lo) && (oy_hi >= iy_hi);
        end
    end

endmodule

// File: rtl/pellet_tracker.sv
// Pellet tracker: sweeps one pellet per cycle against a Pac-Man snapshot,
// keeps eaten bitmap / score / all-eaten, and answers a render query.
module pellet_tracker
    import pellet_tracker_pkg::*;
#(
    parameter int unsigned N_PELLETS      = DEF_N_PELLETS,
    parameter int unsigned IDX_W          = 5,
    parameter int unsigned COORD_W        = DEF_COORD_W,
    parameter int unsigned SPRITE_SZ      = SPRITE_EDGE,
    parameter int unsigned PELLET_SZ      = PELLET_EDGE,
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned PTS_PER_PELLET = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           new_game,
    input  logic                           enable,
    input  logic [N_PELLETS*COORD_W-1:0]   pellet_x,
    input  logic [N_PELLETS*COORD_W-1:0]   pellet_y,
    input  logic [COORD_W-1:0]             pac_x,
    input  logic [COORD_W-1:0]             pac_y,
    input  logic [COORD_W-1:0]             pix_x,
    input  logic [COORD_W-1:0]             pix_y,
    output logic                           pix_hit,
    output logic [IDX_W-1:0]               pix_idx,
    output logic [N_PELLETS-1:0]           eaten,
    output logic [SCORE_W-1:0]             score,
    output logic                           eat_pulse,
    output logic                           all_eaten
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PELLETS - 1);
    localparam logic [31:0]      SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    tracker_state_t state_q, state_d;

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [COORD_W-1:0]   snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [N_PELLETS-1:0] eaten_q, eaten_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 eat_pulse_q, eat_pulse_d;
    logic                 all_eaten_q, all_eaten_d;
    logic                 pix_hit_q, pix_hit_d;
    logic [IDX_W-1:0]     pix_idx_q, pix_idx_d;

    logic                 snap_load, idx_clr, scan_en, set_all;
    logic [COORD_W-1:0]   sel_x, sel_y;
    logic                 sel_eaten, sel_hit;
    logic [N_PELLETS-1:0] pix_in;
    logic [31:0]          score_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = SAMPLE;
            SAMPLE:  state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = CHECK;
            CHECK: begin
                if (&eaten_q)    state_d = WON;
                else if (enable) state_d = SAMPLE;
                else             state_d = IDLE;
            end
            WON:     state_d = WON;
            default: state_d = IDLE;
        endcase
        if (new_game) state_d = IDLE;
    end

    always_comb begin
        snap_load = 1'b0;
        idx_clr   = 1'b0;
        scan_en   = 1'b0;
        set_all   = 1'b0;
        case (state_q)
            SAMPLE: begin
                snap_load = 1'b1;
                idx_clr   = 1'b1;
            end
            SCAN:    scan_en = 1'b1;
            CHECK:   set_all = &eaten_q;
            default: ;
        endcase
    end

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_eaten = 1'b0;
        for (int unsigned i = 0; i < N_PELLETS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_x     = pellet_x[i*COORD_W +: COORD_W];
                sel_y     = pellet_y[i*COORD_W +: COORD_W];
                sel_eaten = eaten_q[i];
            end
        end
    end

    rect_contains #(
        .W        (COORD_W),
        .OUTER_SZ (SPRITE_SZ),
        .INNER_SZ (PELLET_SZ),
        .STRICT   (1'b0)
    ) u_sweep (
        .outer_x_i (snap_x_q),
        .outer_y_i (snap_y_q),
        .inner_x_i (sel_x),
        .inner_y_i (sel_y),
        .hit_o     (sel_hit)
    );

    // new_game is applied last so it overrides any hit in the same cycle.
    always_comb begin
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        idx_d       = idx_q;
        eaten_d     = eaten_q;
        score_d     = score_q;
        eat_pulse_d = 1'b0;
        all_eaten_d = all_eaten_q;
        score_sum   = 32'(score_q) + 32'(PTS_PER_PELLET);

        if (snap_load) begin
            snap_x_d = pac_x;
            snap_y_d = pac_y;
        end
        if (idx_clr)      idx_d = '0;
        else if (scan_en) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

        if (scan_en && sel_hit && !sel_eaten) begin
            eaten_d     = eaten_q | (N_PELLETS'(1) << idx_q);
            score_d     = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX)
                                                  : score_sum[SCORE_W-1:0];
            eat_pulse_d = 1'b1;
        end
        if (set_all) all_eaten_d = 1'b1;

        if (new_game) begin
            idx_d       = '0;
            eaten_d     = '0;
            score_d     = '0;
            eat_pulse_d = 1'b0;
            all_eaten_d = 1'b0;
        end
    end

    for (genvar g = 0; g < N_PELLETS; g++) begin : g_render
        rect_contains #(
            .W        (COORD_W),
            .OUTER_SZ (PELLET_SZ),
            .INNER_SZ (0),
            .STRICT   (1'b1)
        ) u_pix (
            .outer_x_i (pellet_x[g*COORD_W +: COORD_W]),
            .outer_y_i (pellet_y[g*COORD_W +: COORD_W]),
            .inner_x_i (pix_x),
            .inner_y_i (pix_y),
            .hit_o     (pix_in[g])
        );
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        pix_hit_d = 1'b0;
        pix_idx_d = '0;
        for (int unsigned i = N_PELLETS; i > 0; i--) begin
            if (pix_in[i-1] && !eaten_q[i-1]) begin
                pix_hit_d = 1'b1;
                pix_idx_d = IDX_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            eaten_q     <= '0;
            score_q     <= '0;
            eat_pulse_q <= 1'b0;
            all_eaten_q <= 1'b0;
            pix_hit_q   <= 1'b0;
            pix_idx_q   <= '0;
        end else begin
            idx_q       <= idx_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            eaten_q     <= eaten_d;
            score_q     <= score_d;
            eat_pulse_q <= eat_pulse_d;
            all_eaten_q <= all_eaten_d;
            pix_hit_q   <= pix_hit_d;
            pix_idx_q   <= pix_idx_d;
        end
    end

    assign eaten     = eaten_q;
    assign score     = score_q;
    assign eat_pulse = eat_pulse_q;
    assign all_eaten = all_eaten_q;
    assign pix_hit   = pix_hit_q;
    assign pix_idx   = pix_idx_q;

endmodule

// File: tb/tb_pellet_tracker.sv
// Bench for pellet_tracker: whole-sweep reference model (set arithmetic on
// positions), a second instance with a 4-bit score for saturation.
module tb_pellet_tracker;

    localparam int N  = 8;
    localparam int CW = 10;
    localparam int IW = 5;

    logic            clk = 1'b0;
    logic            rst, new_game, enable;
    logic [N*CW-1:0] pellet_x, pellet_y;
    logic [CW-1:0]   pac_x, pac_y, pix_x, pix_y;
    logic            pix_hit, eat_pulse, all_eaten;
    logic [IW-1:0]   pix_idx;
    logic [N-1:0]    eaten;
    logic [7:0]      score;
    logic            s_pix_hit, s_eat_pulse, s_all_eaten;
    logic [IW-1:0]   s_pix_idx;
    logic [N-1:0]    s_eaten;
    logic [3:0]      s_score;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int s_pulses = 0;
    int pulse_cyc[$];
    int sweep_start;

    int px[N], py[N];
    int def_x[N] = '{147, 147, 147, 147, 478, 478, 478, 478};
    int def_y[N] = '{50, 141, 304, 395, 50, 141, 304, 395};

    logic [N-1:0] m_eaten;
    int  m_score, m_sat, m_new;
    bit  m_all;

    pellet_tracker #(
        .N_PELLETS(N), .IDX_W(IW), .COORD_W(CW), .SPRITE_SZ(20), .PELLET_SZ(15),
        .SCORE_W(8), .PTS_PER_PELLET(10)
    ) u_dut (
        .clk(clk), .rst(rst), .new_game(new_game), .enable(enable),
        .pellet_x(pellet_x), .pellet_y(pellet_y), .pac_x(pac_x), .pac_y(pac_y),
        .pix_x(pix_x), .pix_y(pix_y), .pix_hit(pix_hit), .pix_idx(pix_idx),
        .eaten(eaten), .score(score), .eat_pulse(eat_pulse), .all_eaten(all_eaten)
    );

    pellet_tracker #(
        .N_PELLETS(N), .IDX_W(IW), .COORD_W(CW), .SPRITE_SZ(20), .PELLET_SZ(15),
        .SCORE_W(4), .PTS_PER_PELLET(10)
    ) u_sat (
        .clk(clk), .rst(rst), .new_game(new_game), .enable(enable),
        .pellet_x(pellet_x), .pellet_y(pellet_y), .pac_x(pac_x), .pac_y(pac_y),
        .pix_x(pix_x), .pix_y(pix_y), .pix_hit(s_pix_hit), .pix_idx(s_pix_idx),
        .eaten(s_eaten), .score(s_score), .eat_pulse(s_eat_pulse), .all_eaten(s_all_eaten)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eat_pulse === 1'b1) pulse_cyc.push_back(cyc);
        if (s_eat_pulse === 1'b1) s_pulses <= s_pulses + 1;
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        m_eaten = '0;
        m_score = 0;
        m_sat   = 0;
        m_all   = 1'b0;
    endfunction

    function automatic void model_sweep(input int sx, input int sy);
        m_new = 0;
        if (m_all) return;
        for (int i = 0; i < N; i++) begin
            if (!m_eaten[i] && sx <= px[i] && sx + 20 >= px[i] + 15 &&
                sy <= py[i] && sy + 20 >= py[i] + 15) begin
                m_eaten[i] = 1'b1;
                m_new++;
                m_score = (m_score + 10 > 255) ? 255 : m_score + 10;
                m_sat   = (m_sat + 10 > 15) ? 15 : m_sat + 10;
            end
        end
        if (&m_eaten) m_all = 1'b1;
    endfunction

    function automatic void ref_pix(input int qx, input int qy, output logic h, output int idx);
        h = 1'b0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!m_eaten[i] && px[i] < qx && qx < px[i] + 15 && py[i] < qy && qy < py[i] + 15) begin
                h = 1'b1;
                idx = i;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic load_pellets();
        for (int i = 0; i < N; i++) begin
            pellet_x[i*CW +: CW] = CW'(px[i]);
            pellet_y[i*CW +: CW] = CW'(py[i]);
        end
    endtask

    task automatic run_sweep(input int sx, input int sy);
        @(negedge clk);
        pac_x = CW'(sx);
        pac_y = CW'(sy);
        pulse_cyc.delete();
        sweep_start = cyc;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (N + 4) @(negedge clk);
        model_sweep(sx, sy);
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; new_game = 1'b0; enable = 1'b0;
        pac_x = '0; pac_y = '0; pix_x = '0; pix_y = '0;
        for (int i = 0; i < N; i++) begin px[i] = def_x[i]; py[i] = def_y[i]; end
        load_pellets();
        model_clear();
        repeat (3) @(negedge clk);
        n_total++; if (eaten !== '0) $display("FAIL reset_eaten got %h want 0", eaten); else n_pass++;
        n_total++; if (score !== '0) $display("FAIL reset_score got %0d want 0", score); else n_pass++;
        n_total++; if (eat_pulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", eat_pulse); else n_pass++;
        n_total++; if (all_eaten !== 1'b0) $display("FAIL reset_all got %b want 0", all_eaten); else n_pass++;
        n_total++; if (pix_hit !== 1'b0) $display("FAIL reset_pix_hit got %b want 0", pix_hit); else n_pass++;
        n_total++; if (pix_idx !== '0) $display("FAIL reset_pix_idx got %0d want 0", pix_idx); else n_pass++;
        n_total++; if (s_score !== '0) $display("FAIL reset_sat_score got %0d want 0", s_score); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_hit();
        @(negedge clk);
        pac_x = '0; pac_y = '0;
        pulse_cyc.delete();
        enable = 1'b1;
        repeat (3 * (N + 2) + 2) @(negedge clk);
        enable = 1'b0;
        repeat (N + 4) @(negedge clk);
        n_total++; if (eaten !== '0) $display("FAIL nohit_eaten got %h want 0", eaten); else n_pass++;
        n_total++; if (score !== '0) $display("FAIL nohit_score got %0d want 0", score); else n_pass++;
        n_total++; if (pulse_cyc.size() != 0) $display("FAIL nohit_pulses got %0d want 0", pulse_cyc.size()); else n_pass++;
        n_total++; if (all_eaten !== 1'b0) $display("FAIL nohit_all got %b want 0", all_eaten); else n_pass++;
    endtask

    task automatic test_render_basic();
        int   qx[6] = '{150, 147, 161, 162, 150, 480};
        int   qy[6] = '{55, 55, 55, 55, 50, 397};
        logic eh;
        int   ei;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pix_x = CW'(qx[k]);
            pix_y = CW'(qy[k]);
            @(negedge clk);
            ref_pix(qx[k], qy[k], eh, ei);
            n_total++; if (pix_hit !== eh) $display("FAIL render_hit(%0d,%0d) got %b want %b", qx[k], qy[k], pix_hit, eh); else n_pass++;
            n_total++; if (pix_idx !== IW'(ei)) $display("FAIL render_idx(%0d,%0d) got %0d want %0d", qx[k], qy[k], pix_idx, ei); else n_pass++;
            n_total++; if (s_pix_hit !== eh || s_pix_idx !== IW'(ei)) $display("FAIL render_sat(%0d,%0d) got %b/%0d want %b/%0d", qx[k], qy[k], s_pix_hit, s_pix_idx, eh, ei); else n_pass++;
        end
    endtask

    task automatic test_single_hit();
        int extra;
        run_sweep(145, 48);
        n_total++; if (pulse_cyc.size() != 1) $display("FAIL hit_pulses got %0d want 1", pulse_cyc.size()); else n_pass++;
        n_total++;
        if (pulse_cyc.size() == 0 || pulse_cyc[0] < sweep_start + 3 || pulse_cyc[0] > sweep_start + N + 2)
            $display("FAIL hit_pulse_window got %0d want %0d..%0d", (pulse_cyc.size() == 0) ? -1 : pulse_cyc[0] - sweep_start, 3, N + 2);
        else n_pass++;
        n_total++; if (eaten !== m_eaten) $display("FAIL hit_eaten got %h want %h", eaten, m_eaten); else n_pass++;
        n_total++; if (score !== 8'(m_score)) $display("FAIL hit_score got %0d want %0d", score, m_score); else n_pass++;
        n_total++; if (s_pulses != 1) $display("FAIL hit_sat_pulses got %0d want 1", s_pulses); else n_pass++;
        @(negedge clk);
        pix_x = CW'(150); pix_y = CW'(55);
        @(negedge clk);
        n_total++; if (pix_hit !== 1'b0) $display("FAIL hit_render_eaten got %b want 0", pix_hit); else n_pass++;
        extra = 0;
        repeat (5) begin
            run_sweep(145, 48);
            extra += pulse_cyc.size();
        end
        n_total++; if (extra != 0) $display("FAIL hold_pulses got %0d want 0", extra); else n_pass++;
        n_total++; if (score !== 8'(m_score)) $display("FAIL hold_score got %0d want %0d", score, m_score); else n_pass++;
    endtask

    task automatic test_all_eaten();
        for (int i = 1; i < N; i++) begin
            run_sweep(px[i] - 2, py[i] - 2);
            n_total++; if (s_score !== 4'(m_sat)) $display("FAIL sat_score[%0d] got %0d want %0d", i, s_score, m_sat); else n_pass++;
            n_total++; if (pulse_cyc.size() != m_new) $display("FAIL visit_pulses[%0d] got %0d want %0d", i, pulse_cyc.size(), m_new); else n_pass++;
        end
        n_total++; if (eaten !== m_eaten) $display("FAIL won_eaten got %h want %h", eaten, m_eaten); else n_pass++;
        n_total++; if (score !== 8'(m_score)) $display("FAIL won_score got %0d want %0d", score, m_score); else n_pass++;
        n_total++; if (all_eaten !== m_all) $display("FAIL won_all got %b want %b", all_eaten, m_all); else n_pass++;
        n_total++; if (s_all_eaten !== m_all) $display("FAIL won_sat_all got %b want %b", s_all_eaten, m_all); else n_pass++;
        run_sweep(10, 10);
        run_sweep(px[0] - 2, py[0] - 2);
        n_total++; if (pulse_cyc.size() != 0) $display("FAIL won_move_pulses got %0d want 0", pulse_cyc.size()); else n_pass++;
        n_total++; if (score !== 8'(m_score) || eaten !== m_eaten) $display("FAIL won_move got %0d/%h want %0d/%h", score, eaten, m_score, m_eaten); else n_pass++;
    endtask

    task automatic test_new_game_collision();
        do_new_game();
        n_total++; if (eaten !== '0 || all_eaten !== 1'b0) $display("FAIL ng_clear got %h/%b want 0/0", eaten, all_eaten); else n_pass++;
        run_sweep(145, 48);
        n_total++; if (eaten !== m_eaten) $display("FAIL ng_pre_eaten got %h want %h", eaten, m_eaten); else n_pass++;
        @(negedge clk);
        pac_x = CW'(145); pac_y = CW'(393);
        pulse_cyc.delete();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        repeat (N + 4) @(negedge clk);
        n_total++; if (eaten !== '0) $display("FAIL ng_eaten got %h want 0", eaten); else n_pass++;
        n_total++; if (score !== '0) $display("FAIL ng_score got %0d want 0", score); else n_pass++;
        n_total++; if (pulse_cyc.size() != 0) $display("FAIL ng_pulses got %0d want 0", pulse_cyc.size()); else n_pass++;
        n_total++; if (s_score !== '0) $display("FAIL ng_sat_score got %0d want 0", s_score); else n_pass++;
        run_sweep(145, 393);
        n_total++; if (eaten !== m_eaten) $display("FAIL ng_after_eaten got %h want %h", eaten, m_eaten); else n_pass++;
        n_total++; if (pulse_cyc.size() != m_new) $display("FAIL ng_after_pulses got %0d want %0d", pulse_cyc.size(), m_new); else n_pass++;
    endtask

    task automatic test_identical();
        do_new_game();
        px[0] = 300; py[0] = 200; px[1] = 300; py[1] = 200;
        load_pellets();
        run_sweep(298, 198);
        n_total++; if (pulse_cyc.size() != 2) $display("FAIL twin_pulses got %0d want 2", pulse_cyc.size()); else n_pass++;
        n_total++;
        if (pulse_cyc.size() != 2 || pulse_cyc[1] != pulse_cyc[0] + 1)
            $display("FAIL twin_consecutive got gap %0d want 1", (pulse_cyc.size() == 2) ? pulse_cyc[1] - pulse_cyc[0] : -1);
        else n_pass++;
        n_total++; if (eaten !== m_eaten) $display("FAIL twin_eaten got %h want %h", eaten, m_eaten); else n_pass++;
        n_total++; if (score !== 8'(m_score)) $display("FAIL twin_score got %0d want %0d", score, m_score); else n_pass++;
        for (int i = 0; i < N; i++) begin px[i] = def_x[i]; py[i] = def_y[i]; end
        load_pellets();
    endtask

    task automatic test_async_reset();
        do_new_game();
        run_sweep(145, 48);
        @(negedge clk);
        pix_x = CW'(150); pix_y = CW'(307);
        @(negedge clk);
        n_total++; if (pix_hit !== 1'b1) $display("FAIL ar_pre_pix got %b want 1", pix_hit); else n_pass++;
        pac_x = CW'(145); pac_y = CW'(139);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++; if (eaten !== '0) $display("FAIL ar_eaten got %h want 0", eaten); else n_pass++;
        n_total++; if (score !== '0) $display("FAIL ar_score got %0d want 0", score); else n_pass++;
        n_total++; if (eat_pulse !== 1'b0 || all_eaten !== 1'b0) $display("FAIL ar_flags got %b/%b want 0/0", eat_pulse, all_eaten); else n_pass++;
        n_total++; if (pix_hit !== 1'b0 || pix_idx !== '0) $display("FAIL ar_pix got %b/%0d want 0/0", pix_hit, pix_idx); else n_pass++;
        n_total++; if (s_score !== '0) $display("FAIL ar_sat_score got %0d want 0", s_score); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_random();
        int   t, sx, sy, qx, qy, ei;
        logic eh;
        for (int g = 0; g < 4; g++) begin
            do_new_game();
            for (int i = 0; i < N; i++) begin
                px[i] = (g % 2 == 0) ? int'($urandom_range(980, 1023)) : int'($urandom_range(100, 160));
                py[i] = (g % 2 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(400, 460));
            end
            load_pellets();
            for (int it = 0; it < 8; it++) begin
                t  = int'($urandom_range(0, N - 1));
                sx = px[t] - int'($urandom_range(0, 7));
                sy = py[t] - int'($urandom_range(0, 7));
                if (sx < 0) sx = 0;
                if (sy < 0) sy = 0;
                run_sweep(sx, sy);
                n_total++; if (eaten !== m_eaten) $display("FAIL rnd_eaten got %h want %h", eaten, m_eaten); else n_pass++;
                n_total++; if (score !== 8'(m_score)) $display("FAIL rnd_score got %0d want %0d", score, m_score); else n_pass++;
                n_total++; if (s_score !== 4'(m_sat)) $display("FAIL rnd_sat_score got %0d want %0d", s_score, m_sat); else n_pass++;
                n_total++; if (pulse_cyc.size() != m_new) $display("FAIL rnd_pulses got %0d want %0d", pulse_cyc.size(), m_new); else n_pass++;
                n_total++; if (all_eaten !== m_all) $display("FAIL rnd_all got %b want %b", all_eaten, m_all); else n_pass++;
                qx = px[t] + int'($urandom_range(0, 16));
                qy = py[t] + int'($urandom_range(0, 16));
                if (qx > 1023) qx = 1023;
                if (qy > 1023) qy = 1023;
                @(negedge clk);
                pix_x = CW'(qx); pix_y = CW'(qy);
                @(negedge clk);
                ref_pix(qx, qy, eh, ei);
                n_total++; if (pix_hit !== eh) $display("FAIL rnd_pix_hit(%0d,%0d) got %b want %b", qx, qy, pix_hit, eh); else n_pass++;
                n_total++; if (pix_idx !== IW'(ei)) $display("FAIL rnd_pix_idx(%0d,%0d) got %0d want %0d", qx, qy, pix_idx, ei); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_hit();
        test_render_basic();
        test_single_hit();
        test_all_eaten();
        test_new_game_collision();
        test_identical();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
